// File: rtl/stream_mux_rr_if.sv
// Stream mux handshake bundle: N valid/ready input lanes and one valid/ready output lane.
// STREAM_MUX_RR_PACKET_LOCK_EN adds per-lane in_last and a registered out_last.
// Producer/consumer side uses the master modport; the mux uses the slave modport.
interface stream_mux_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// Round-robin N:1 stream mux with a single registered output stage; optional packet lock via STREAM_MUX_RR_PACKET_LOCK_EN.
// Latency: 1 cycle from input handshake to out_valid; 1 beat/cycle sustained.
// Backpressure: a held beat with out_ready low freezes the output and pointer and drops all in_ready.
module stream_mux_rr #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;

    logic [SW-1:0] gnt;
    logic          gnt_vld;
    logic          can_load;
    logic          load;
    logic [SW-1:0] gnt_succ;

`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } lock_st_e;

    lock_st_e      lock_st_q, lock_st_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic          out_last_q, out_last_d;
`endif

    // Rotating priority search starting at ptr_q; idx is one bit wider so ptr+k never overflows before the wrap.
    always_comb begin : arbiter
        logic [SW:0] idx;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (SW+1)'(k);
            if (idx >= (SW+1)'(N)) begin
                idx = idx - (SW+1)'(N);
            end
            if (!gnt_vld && bus.in_valid[idx[SW-1:0]]) begin
                gnt     = idx[SW-1:0];
                gnt_vld = 1'b1;
            end
        end
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
        if (lock_st_q == ST_LOCK) begin
            gnt     = lock_ch_q;
            gnt_vld = bus.in_valid[lock_ch_q];
        end
`endif
    end

    assign can_load = !out_valid_q || bus.out_ready;
    assign load     = can_load && gnt_vld;
    assign gnt_succ = (gnt == SW'(N-1)) ? '0 : gnt + 1'b1;

    always_comb begin : ready_gen
        bus.in_ready = '0;
        if (load) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin : next_state
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
        lock_st_d   = lock_st_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (can_load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = bus.in_data[gnt*W +: W];
                out_sel_d  = gnt;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
                out_last_d = bus.in_last[gnt];
                // Pointer moves only when a packet closes, so the lock owner keeps its turn mid-packet.
                if (bus.in_last[gnt]) begin
                    lock_st_d = ST_ARB;
                    ptr_d     = gnt_succ;
                end else begin
                    lock_st_d = ST_LOCK;
                    lock_ch_d = gnt;
                end
`else
                ptr_d      = gnt_succ;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
            lock_st_q   <= ST_ARB;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
            lock_st_q   <= lock_st_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
    assign bus.out_last  = out_last_q;
`endif

endmodule
